hsv_rgb_pwm: RTL



---
 rtl/hsv_rgb_pwm_pkg.sv | 38 +++
 rtl/hsv_rgb_pwm_seq_div.sv | 73 +++++++
 rtl/hsv_rgb_pwm.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsv_rgb_pwm_pkg.sv
// Shared definitions for the HSV -> RGB -> PWM LED block.
//   - state_t     : conversion FSM states
//   - HUE_WRAP    : hue values at or above this wrap back by this amount
//   - PCT_MAX     : saturation/value ceiling in percent
//   - SECTOR_DEG  : width of one hue sector in degrees
//   - CH_MAX      : full-scale colour channel
//   - DIV_BITS    : dividend width / iteration count of the sequential divider
//   - LATENCY     : cycles from input accept edge to out_valid
package hsv_rgb_pwm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLAMP,
        S_SECTOR,
        S_DIV_V,
        S_DIV_C,
        S_DIV_X,
        S_ASSEMBLE
    } state_t;

    localparam logic [8:0] HUE_WRAP   = 9'd360;
    localparam logic [8:0] PCT_MAX    = 9'd100;
    localparam logic [8:0] SECTOR_DEG = 9'd60;
    localparam logic [7:0] CH_MAX     = 8'd255;

    localparam int DIV_BITS = 16;

    // Each DIV_* state: 1 start cycle, DIV_BITS iterations, 1 done cycle,
    // 1 capture cycle. Add CLAMP, SECTOR and ASSEMBLE.
    localparam int DIV_STATE_CYCLES = DIV_BITS + 3;
    localparam int LATENCY          = 3 + 3 * DIV_STATE_CYCLES;

    // Saturate a percentage to PCT_MAX.
    function automatic logic [8:0] pct_clamp(input logic [8:0] p);
        return (p > PCT_MAX) ? PCT_MAX : p;
    endfunction

endpackage

// File: rtl/hsv_rgb_pwm_seq_div.sv
// Restoring sequential divider: 16-bit dividend / 8-bit divisor.
//   clk, reset   : clock, synchronous active-high reset
//   start        : load operands (ignored while a division is running)
//   dividend     : 16-bit unsigned numerator
//   divisor      : 8-bit unsigned denominator, must be non-zero
//   done         : one-cycle pulse, quotient/remainder valid from then on
//   quotient     : floor(dividend / divisor)
//   remainder    : dividend mod divisor
// Timing: start sampled at edge E, 16 iteration edges, done high after E+17.
module hsv_rgb_pwm_seq_div
    import hsv_rgb_pwm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder
);

    logic [15:0] quo_reg;
    logic [7:0]  rem_reg;
    logic [7:0]  div_reg;
    logic [4:0]  cnt_reg;
    logic        busy_reg;
    logic        done_reg;

    // Partial remainder is always below the divisor, so the shifted value
    // fits in 9 bits and the post-subtract value fits back into 8.
    logic [8:0] rem_shift;
    logic       rem_ge;
    logic [8:0] rem_next;

    assign rem_shift = {rem_reg, quo_reg[15]};
    assign rem_ge    = (rem_shift >= {1'b0, div_reg});
    assign rem_next  = rem_ge ? (rem_shift - {1'b0, div_reg}) : rem_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_reg  <= '0;
            rem_reg  <= '0;
            div_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (busy_reg) begin
                if (cnt_reg == 5'(DIV_BITS)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end else begin
                    rem_reg <= rem_next[7:0];
                    quo_reg <= {quo_reg[14:0], rem_ge};
                    cnt_reg <= cnt_reg + 5'd1;
                end
            end else if (start) begin
                quo_reg  <= dividend;
                rem_reg  <= '0;
                div_reg  <= divisor;
                cnt_reg  <= '0;
                busy_reg <= 1'b1;
            end
        end
    end

    assign done      = done_reg;
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/hsv_rgb_pwm.sv
// HSV to RGB converter driving three PWM outputs for the board RGB LED.
//   clk, reset          : clock, synchronous active-high reset
//   hue, sat, val       : 9-bit input triple (degrees, percent, percent)
//   in_valid, in_ready  : input handshake, accept on in_valid & in_ready
//   r, g, b             : last converted colour
//   out_valid           : one-cycle pulse when r/g/b update
//   led_r, led_g, led_b : PWM outputs, high while counter < duty
// One conversion at a time; latency is the constant LATENCY from the package.
module hsv_rgb_pwm
    import hsv_rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int MAX_LATENCY = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8:0]          hue,
    input  logic [8:0]          sat,
    input  logic [8:0]          val,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [PWM_BITS-1:0] r,
    output logic [PWM_BITS-1:0] g,
    output logic [PWM_BITS-1:0] b,
    output logic                out_valid,
    output logic                led_r,
    output logic                led_g,
    output logic                led_b
);

    state_t state_reg, state_next;
    logic   div_wait_reg, div_wait_next;
    logic   div_start;
    logic   div_capture;

    logic [8:0] hue_reg, sat_reg, val_reg;
    logic [2:0] sector_reg;
    logic [5:0] f_reg;
    logic [7:0] vs_reg, c_reg, x_reg;
    logic [7:0] r_reg, g_reg, b_reg;
    logic       out_valid_reg;

    logic [15:0] div_dividend;
    logic [7:0]  div_divisor;
    logic        div_done;
    logic [15:0] div_quo;
    logic [7:0]  div_rem;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            div_wait_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_wait_reg <= div_wait_next;
        end
    end

    // Each DIV_* state kicks the divider on its first cycle and then waits
    // for done; div_wait_reg distinguishes the two phases.
    always_comb begin
        state_next    = state_reg;
        div_wait_next = div_wait_reg;
        div_start     = 1'b0;
        div_capture   = 1'b0;
        case (state_reg)
            S_IDLE:   if (in_valid) state_next = S_CLAMP;
            S_CLAMP:  state_next = S_SECTOR;
            S_SECTOR: state_next = S_DIV_V;
            S_DIV_V, S_DIV_C, S_DIV_X: begin
                if (!div_wait_reg) begin
                    div_start     = 1'b1;
                    div_wait_next = 1'b1;
                end else if (div_done) begin
                    div_wait_next = 1'b0;
                    div_capture   = 1'b1;
                    if (state_reg == S_DIV_V)      state_next = S_DIV_C;
                    else if (state_reg == S_DIV_C) state_next = S_DIV_X;
                    else                           state_next = S_ASSEMBLE;
                end
            end
            S_ASSEMBLE: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    assign in_ready = (state_reg == S_IDLE) && !reset;

    // ---------------- sector / fraction ----------------
    // Unrolled compare-subtract chain; hue is already below 360 here, so
    // five steps are enough and the residue is the in-sector offset.
    logic [8:0] h_stage [0:5];
    logic [4:0] step_ge;
    logic [2:0] sector_calc;

    assign h_stage[0] = hue_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sector
            assign step_ge[gi]   = (h_stage[gi] >= SECTOR_DEG);
            assign h_stage[gi+1] = step_ge[gi] ? (h_stage[gi] - SECTOR_DEG) : h_stage[gi];
        end
    endgenerate

    always_comb begin
        sector_calc = '0;
        for (int i = 0; i < 5; i++) begin
            sector_calc = sector_calc + {2'b00, step_ge[i]};
        end
    end

    // ---------------- divider operands ----------------
    logic [15:0] val16;
    logic [5:0]  f_sel;

    assign val16 = {7'd0, val_reg};
    // Odd sectors have a falling secondary component.
    assign f_sel = sector_reg[0] ? (6'd60 - f_reg) : f_reg;

    always_comb begin
        div_dividend = (val16 << 8) - val16;    // val * 255
        div_divisor  = PCT_MAX[7:0];
        case (state_reg)
            S_DIV_C: begin
                div_dividend = {8'd0, vs_reg} * {7'd0, sat_reg};
                div_divisor  = PCT_MAX[7:0];
            end
            S_DIV_X: begin
                div_dividend = {8'd0, c_reg} * {10'd0, f_sel};
                div_divisor  = SECTOR_DEG[7:0];
            end
            default: ;
        endcase
    end

    hsv_rgb_pwm_seq_div u_seq_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // ---------------- channel assembly ----------------
    logic [7:0] m_val;
    logic [7:0] ch_r, ch_g, ch_b;

    assign m_val = vs_reg - c_reg;

    always_comb begin
        ch_r = '0;
        ch_g = '0;
        ch_b = '0;
        case (sector_reg)
            3'd0: begin ch_r = c_reg; ch_g = x_reg; end
            3'd1: begin ch_r = x_reg; ch_g = c_reg; end
            3'd2: begin ch_g = c_reg; ch_b = x_reg; end
            3'd3: begin ch_g = x_reg; ch_b = c_reg; end
            3'd4: begin ch_r = x_reg; ch_b = c_reg; end
            3'd5: begin ch_r = c_reg; ch_b = x_reg; end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hue_reg       <= '0;
            sat_reg       <= '0;
            val_reg       <= '0;
            sector_reg    <= '0;
            f_reg         <= '0;
            vs_reg        <= '0;
            c_reg         <= '0;
            x_reg         <= '0;
            r_reg         <= '0;
            g_reg         <= '0;
            b_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        hue_reg <= hue;
                        sat_reg <= sat;
                        val_reg <= val;
                    end
                end
                S_CLAMP: begin
                    // 511 - 360 < 360, so a single subtract suffices.
                    hue_reg <= (hue_reg >= HUE_WRAP) ? (hue_reg - HUE_WRAP) : hue_reg;
                    sat_reg <= pct_clamp(sat_reg);
                    val_reg <= pct_clamp(val_reg);
                end
                S_SECTOR: begin
                    sector_reg <= sector_calc;
                    f_reg      <= h_stage[5][5:0];
                end
                S_DIV_V: if (div_capture) vs_reg <= div_quo[7:0];
                S_DIV_C: if (div_capture) c_reg  <= div_quo[7:0];
                S_DIV_X: if (div_capture) x_reg  <= div_quo[7:0];
                S_ASSEMBLE: begin
                    // Sum is bounded by Vs <= CH_MAX, no overflow possible.
                    r_reg         <= ch_r + m_val;
                    g_reg         <= ch_g + m_val;
                    b_reg         <= ch_b + m_val;
                    out_valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign r         = r_reg;
    assign g         = g_reg;
    assign b         = b_reg;
    assign out_valid = out_valid_reg;

    // ---------------- PWM ----------------
    // led is registered from the next-state counter and duty, so it equals
    // (cnt < duty) for the current cycle while still coming straight from a flop.
    logic [PWM_BITS-1:0] cnt_reg, cnt_next;
    logic [PWM_BITS-1:0] ch_val [0:2];
    logic [2:0]          led_vec;

    assign cnt_next  = cnt_reg + PWM_BITS'(1);
    assign ch_val[0] = r_reg;
    assign ch_val[1] = g_reg;
    assign ch_val[2] = b_reg;

    always_ff @(posedge clk) begin
        if (reset) cnt_reg <= '0;
        else       cnt_reg <= cnt_next;
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_pwm
            logic [PWM_BITS-1:0] duty_reg, duty_next;
            logic                led_reg;

            // Duty only changes at the period boundary to avoid glitches.
            assign duty_next = (cnt_reg == {PWM_BITS{1'b1}}) ? ch_val[gi] : duty_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    duty_reg <= '0;
                    led_reg  <= 1'b0;
                end else begin
                    duty_reg <= duty_next;
                    led_reg  <= (cnt_next < duty_next);
                end
            end

            assign led_vec[gi] = led_reg;
        end
    endgenerate

    assign led_r = led_vec[0];
    assign led_g = led_vec[1];
    assign led_b = led_vec[2];

endmodule
